// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and cell packing for the text console writer.
package text_console_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned ROWS_DEF   = 30;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam logic [5:0]  ATTR_DEF   = 6'b000_111;

  localparam logic [7:0] CH_BS        = 8'h08;
  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [7:0] CH_CR        = 8'h0D;
  localparam logic [7:0] CH_SPACE     = 8'h20;
  localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_t;

  // RAM cell: {18'b0, bg[2:0], fg[2:0], char[7:0]}
  function automatic logic [31:0] pack_cell(input logic [5:0] attr, input logic [7:0] ch);
    return {18'b0, attr, ch};
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream handshake plus character RAM write port.
//   master: byte source / RAM observer   slave: the writer block
//   char_in, attr_in, char_valid  -> writer
//   char_ready, data_b, addr_b, we_b <- writer
interface text_console_writer_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [7:0]        char_in;
  logic [5:0]        attr_in;
  logic              char_valid;
  logic              char_ready;
  logic [31:0]       data_b;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;

  modport master (
    output char_in, attr_in, char_valid,
    input  char_ready, data_b, addr_b, we_b
  );

  modport slave (
    input  char_in, attr_in, char_valid,
    output char_ready, data_b, addr_b, we_b
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: consumes ASCII bytes, tracks a cursor, writes packed
// cells to the character RAM and runs row / full-screen clears.
//   clk, rst (async active-low)
//   bus        : byte handshake in, RAM write port out (slave modport)
//   cursor_col : current column 0..COLS-1
//   cursor_row : current row 0..ROWS-1
//   busy       : a clear is in progress
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter logic [5:0]  DEFAULT_ATTR = ATTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  text_console_writer_if.slave bus,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam int unsigned       CELLS    = ROWS * COLS;
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(CELLS - 1);
  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]        ROW_MAX  = 5'(ROWS - 1);
  localparam logic [31:0]       FILL     = pack_cell(DEFAULT_ATTR, CH_SPACE);

  state_t            state, state_n;
  logic [6:0]        col_n;
  logic [4:0]        row_n;
  logic [ADDR_W-1:0] row_base, base_n;
  logic [ADDR_W-1:0] clr_cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       data_n;
  logic              we_n;
  logic              is_print;
  logic [4:0]        row_adv;
  logic [ADDR_W-1:0] base_adv;

  assign is_print = (bus.char_in >= CH_SPACE) && (bus.char_in <= CH_PRINT_MAX);

  // Next row with wrap; row_base tracks row*COLS by addition only.
  assign row_adv  = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
  assign base_adv = (cursor_row == ROW_MAX) ? '0 : row_base + COLS_A;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cursor_col     <= '0;
      cursor_row     <= '0;
      row_base       <= '0;
      clr_cnt        <= '0;
      bus.we_b       <= 1'b0;
      bus.addr_b     <= '0;
      bus.data_b     <= '0;
      bus.char_ready <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      cursor_col     <= col_n;
      cursor_row     <= row_n;
      row_base       <= base_n;
      clr_cnt        <= cnt_n;
      bus.we_b       <= we_n;
      bus.addr_b     <= addr_n;
      bus.data_b     <= data_n;
      bus.char_ready <= (state_n == IDLE);
      busy           <= (state_n != IDLE);
    end
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_n = state;
    col_n   = cursor_col;
    row_n   = cursor_row;
    base_n  = row_base;
    cnt_n   = clr_cnt;
    we_n    = 1'b0;
    addr_n  = bus.addr_b;
    data_n  = bus.data_b;

    unique case (state)
      IDLE: begin
        // char_ready mirrors IDLE, so char_valid here is an accepted transfer.
        if (bus.char_valid) begin
          if (is_print) begin
            we_n   = 1'b1;
            addr_n = row_base + ADDR_W'(cursor_col);
            data_n = pack_cell(bus.attr_in, bus.char_in);
            if (cursor_col == COL_LAST) begin
              col_n   = '0;
              row_n   = row_adv;
              base_n  = base_adv;
              cnt_n   = '0;
              state_n = CLR_ROW;
            end else begin
              col_n = cursor_col + 7'd1;
            end
          end else begin
            case (bus.char_in)
              CH_LF: begin
                col_n   = '0;
                row_n   = row_adv;
                base_n  = base_adv;
                cnt_n   = '0;
                state_n = CLR_ROW;
              end
              CH_CR: col_n = '0;
              CH_BS: if (cursor_col != 7'd0) col_n = cursor_col - 7'd1;
              CH_FF: begin
                cnt_n   = '0;
                state_n = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      // row_base already points at the new row.
      CLR_ROW: begin
        we_n   = 1'b1;
        addr_n = row_base + clr_cnt;
        data_n = FILL;
        cnt_n  = clr_cnt + 1'b1;
        if (clr_cnt == ROW_LAST) state_n = IDLE;
      end

      CLR_ALL: begin
        we_n   = 1'b1;
        addr_n = clr_cnt;
        data_n = FILL;
        cnt_n  = clr_cnt + 1'b1;
        if (clr_cnt == ALL_LAST) begin
          col_n   = '0;
          row_n   = '0;
          base_n  = '0;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized bench for text_console_writer against a cursor/screen model.
module tb_text_console_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [31:0] FILL = 32'h0000_0720;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cursor position and the ordered list of RAM writes still due.
  int          m_col = 0;
  int          m_row = 0;
  bit          m_home = 1'b0;
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  text_console_writer_if #(.ADDR_W(12)) bus ();

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_wr(input int a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endfunction

  function automatic int new_line();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, FILL);
    return COLS;
  endfunction

  // Returns the number of clear cycles the byte starts.
  function automatic int model_accept(input logic [7:0] ch, input logic [5:0] at);
    int k = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, {18'b0, at, ch});
      m_col++;
      if (m_col == COLS) k = new_line();
    end else if (ch == 8'h0A) begin
      k = new_line();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (ch == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) push_wr(i, FILL);
      m_home = 1'b1;
      k = CELLS;
    end
    return k;
  endfunction

  // Every RAM write must be the next one the model expects, inside the screen.
  always @(negedge clk) begin
    if (rst && bus.we_b) begin
      check("addr_range", 32'(bus.addr_b < 12'(CELLS)), 32'd1);
      if (exp_addr.size() == 0) begin
        check("unexpected_we", 32'(bus.we_b), 32'd0);
      end else begin
        check("wr_addr", 32'(bus.addr_b), 32'(exp_addr.pop_front()));
        check("wr_data", bus.data_b, exp_data.pop_front());
      end
    end
  end

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
  endtask

  // Counts cycles with char_ready low after a clear starts.
  task automatic wait_idle(input int k);
    int cnt = 0;
    check("busy_start", 32'(busy), 32'd1);
    while (!bus.char_ready && cnt < k + 20) begin
      @(negedge clk);
      cnt++;
    end
    check("clear_len", 32'(cnt), 32'(k));
    check("busy_end", 32'(busy), 32'd0);
    if (m_home) begin
      m_col  = 0;
      m_row  = 0;
      m_home = 1'b0;
    end
    check_cursor("after_clear");
  endtask

  // Called at a negedge; returns with the byte accepted, at the following negedge.
  task automatic send(input logic [7:0] ch, input logic [5:0] at, output int waited);
    int k;
    waited = 0;
    while (!bus.char_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) check("ready_timeout", 32'(bus.char_ready), 32'd1);
    bus.char_in    = ch;
    bus.attr_in    = at;
    bus.char_valid = 1'b1;
    @(posedge clk);
    k = model_accept(ch, at);
    @(negedge clk);
    bus.char_valid = 1'b0;
    check_cursor("cursor");
    if (k > 0) wait_idle(k);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] b;
    if (r < 70)      b = 8'($urandom_range(32, 126));
    else if (r < 77) b = 8'h0A;
    else if (r < 84) b = 8'h0D;
    else if (r < 91) b = 8'h08;
    else if (r < 92) b = 8'h0C;
    else begin
      b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(0, 31));
      if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
    end
    return b;
  endfunction

  initial begin
    int w;
    int guard;
    bus.char_in    = 8'h00;
    bus.attr_in    = 6'h00;
    bus.char_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_we", 32'(bus.we_b), 32'd0);
    check("rst_addr", 32'(bus.addr_b), 32'd0);
    check("rst_data", bus.data_b, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_cursor("rst");
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.char_ready), 32'd1);

    // First character, latency 1
    send(8'h41, 6'b000_111, w);
    check("a_we", 32'(bus.we_b), 32'd1);
    check("a_addr", 32'(bus.addr_b), 32'd0);
    check("a_data", bus.data_b, 32'h0000_0741);
    check("a_ready", 32'(bus.char_ready), 32'd1);

    // Full row back-to-back, wrapping into a row clear
    send(8'h0D, 6'd0, w);
    for (int i = 0; i < COLS; i++) begin
      send(8'($urandom_range(32, 126)), 6'($urandom_range(0, 63)), w);
      check("b2b_stall", 32'(w), 32'd0);
    end
    check("wrap_row", 32'(cursor_row), 32'd1);

    // Form feed
    send(8'h0C, 6'd0, w);
    check("ff_col", 32'(cursor_col), 32'd0);

    // "AB", BS, CR, LF
    send(8'h41, 6'b010_101, w);
    send(8'h42, 6'b001_110, w);
    check("ab_col", 32'(cursor_col), 32'd2);
    send(8'h08, 6'd0, w);
    check("bs_col", 32'(cursor_col), 32'd1);
    send(8'h0D, 6'd0, w);
    check("cr_col", 32'(cursor_col), 32'd0);
    send(8'h0A, 6'd0, w);
    check("lf_row", 32'(cursor_row), 32'd1);

    // Walk to the last row, then LF wraps to row 0
    while (m_row != ROWS - 1) send(8'h0A, 6'd0, w);
    send(8'h0A, 6'd0, w);
    check("lf_wrap_row", 32'(cursor_row), 32'd0);

    // Random byte stream
    for (int i = 0; i < 300; i++) send(rand_byte(), 6'($urandom_range(0, 63)), w);

    // Reset in the middle of a full-screen clear
    bus.char_in    = 8'h0C;
    bus.char_valid = 1'b1;
    @(posedge clk);
    w = model_accept(8'h0C, 6'd0);
    @(negedge clk);
    bus.char_valid = 1'b0;
    guard = 0;
    while (!(bus.we_b && bus.addr_b == 12'd1000) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("ff_reach_1000", 32'(bus.addr_b), 32'd1000);
    #2 rst = 1'b0;
    #1;
    exp_addr.delete();
    exp_data.delete();
    m_col  = 0;
    m_row  = 0;
    m_home = 1'b0;
    check("arst_we", 32'(bus.we_b), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check_cursor("arst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.char_ready), 32'd1);
    send(8'h5A, 6'b000_111, w);
    check("z_addr", 32'(bus.addr_b), 32'd0);
    check("z_data", bus.data_b, 32'h0000_075A);

    repeat (3) @(negedge clk);
    check("writes_left", 32'(exp_addr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
